// File: rtl/regfile_pkg.sv
// Shared constants for the multi-ported register file.
// Used by regfile_mp and regfile_scoreboard.
package regfile_pkg;

  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic REGWE_WRITE = 1'b1;
  localparam int X0 = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write counters, issue acceptance and busy flags.
// REGFILE_BYPASS_EN: busy reflects same-cycle write retirements.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int PEND_W = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD*AW-1:0] rs_addr,
  output logic [NUM_RD-1:0]    rs_busy,
  input  logic [NUM_WR-1:0]    we,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  output logic                 iss_stall
);

  localparam int PMAX = (1 << PEND_W) - 1;

  logic [PEND_W-1:0] cnt     [DEPTH];
  logic [PEND_W-1:0] cnt_nxt [DEPTH];
  logic [PEND_W-1:0] eff     [DEPTH];
  int                hits    [DEPTH];
  logic              accept;
  logic              iss_ok;

  // Count write ports retiring a producer of each register
  always_comb begin
    for (int r = 0; r < DEPTH; r++) hits[r] = 0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (we[p] == REGWE_WRITE) begin
        hits[wr_addr[p*AW +: AW]] += 1;
      end
    end
  end

  // Effective count, acceptance and clamped next count
  always_comb begin
    int d;
    d = 0;
    iss_ok = iss_valid && (int'(iss_rd) != X0);
    for (int r = 0; r < DEPTH; r++) begin
      d = int'(cnt[r]) - hits[r];
      eff[r] = (d > 0) ? PEND_W'(d) : '0;
    end
    accept = iss_ok && (int'(eff[iss_rd]) < PMAX);
    iss_stall = iss_ok && !accept;
    for (int r = 0; r < DEPTH; r++) begin
      d = int'(cnt[r]) - hits[r];
      if (accept && int'(iss_rd) == r) d = d + 1;
      if (d < 0) d = 0;
      if (d > PMAX) d = PMAX;
      cnt_nxt[r] = (r == X0) ? '0 : PEND_W'(d);
    end
  end

  // Counter state, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) cnt[r] <= cnt_nxt[r];
    end
  end

  // Busy flag per read port, x0 never busy
  always_comb begin
    logic [AW-1:0] a;
    a = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a = rs_addr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      rs_busy[i] = (int'(a) != X0) && (eff[a] != '0);
`else
      rs_busy[i] = (int'(a) != X0) && (cnt[a] != '0);
`endif
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with pending-write scoreboard.
// REGFILE_BYPASS_EN: reads forward same-cycle write data.
module regfile_mp #(
  parameter int XLEN = regfile_pkg::XLEN,
  parameter int DEPTH = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int PEND_W = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   rs_addr,
  output logic [NUM_RD*XLEN-1:0] rs_data,
  output logic [NUM_RD-1:0]      rs_busy,
  input  logic [NUM_WR-1:0]      we,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  input  logic                   iss_valid,
  input  logic [AW-1:0]          iss_rd,
  output logic                   iss_stall
);

  import regfile_pkg::*;

  logic [XLEN-1:0] rf [DEPTH];

  // Data array; later ports overwrite earlier ones on collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) rf[r] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (we[p] == REGWE_WRITE &&
            int'(wr_addr[p*AW +: AW]) != X0) begin
          rf[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
        end
      end
    end
  end

  // Read muxes; x0 reads zero, bypass favours highest port
  always_comb begin
    logic [AW-1:0] a;
    a = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a = rs_addr[i*AW +: AW];
      rs_data[i*XLEN +: XLEN] = rf[a];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < NUM_WR; p++) begin
        if (!rst && we[p] == REGWE_WRITE &&
            wr_addr[p*AW +: AW] == a) begin
          rs_data[i*XLEN +: XLEN] = wr_data[p*XLEN +: XLEN];
        end
      end
`endif
      if (int'(a) == X0) rs_data[i*XLEN +: XLEN] = '0;
    end
  end

  regfile_scoreboard #(
    .DEPTH  (DEPTH),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR),
    .PEND_W (PEND_W)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .rs_addr   (rs_addr),
    .rs_busy   (rs_busy),
    .we        (we),
    .wr_addr   (wr_addr),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_stall (iss_stall)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed cases plus random traffic
// checked against a cycle-level reference model.
module tb_regfile_mp;

  localparam int XL = 32;
  localparam int DP = 32;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int AW = 5;
  localparam int PMAX = 3;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [NR*AW-1:0] rs_addr;
  logic [NR*XL-1:0] rs_data;
  logic [NR-1:0] rs_busy;
  logic [NW-1:0] we;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*XL-1:0] wr_data;
  logic iss_valid;
  logic [AW-1:0] iss_rd;
  logic iss_stall;

  int n_chk = 0;
  int n_fail = 0;

  logic [XL-1:0] mrf [DP];
  int mcnt [DP];

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk       (clk),
    .rst       (rst),
    .rs_addr   (rs_addr),
    .rs_data   (rs_data),
    .rs_busy   (rs_busy),
    .we        (we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_stall (iss_stall)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int waddr(int p);
    return int'(wr_addr[p*AW +: AW]);
  endfunction

  function automatic int hits(int r);
    int k = 0;
    for (int p = 0; p < NW; p++)
      if (we[p] && waddr(p) == r) k++;
    return k;
  endfunction

  function automatic int eff_cnt(int r);
    int d = mcnt[r] - hits(r);
    return (d < 0) ? 0 : d;
  endfunction

  function automatic bit exp_stall();
    if (!iss_valid || iss_rd == 0) return 1'b0;
    return eff_cnt(int'(iss_rd)) >= PMAX;
  endfunction

  function automatic bit exp_busy(int a);
    if (a == 0) return 1'b0;
    return BYP ? (eff_cnt(a) != 0) : (mcnt[a] != 0);
  endfunction

  function automatic logic [XL-1:0] exp_data(int a);
    logic [XL-1:0] v;
    if (a == 0) return '0;
    v = mrf[a];
    if (BYP)
      for (int p = 0; p < NW; p++)
        if (we[p] && waddr(p) == a) v = wr_data[p*XL +: XL];
    return v;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < DP; r++) begin
      mrf[r] = '0;
      mcnt[r] = 0;
    end
  endtask

  task automatic tick();
    logic [XL-1:0] nrf [DP];
    int ncnt [DP];
    bit acc;
    int d;
    acc = iss_valid && iss_rd != 0 && !exp_stall();
    nrf = mrf;
    for (int p = 0; p < NW; p++)
      if (we[p] && waddr(p) != 0) nrf[waddr(p)] = wr_data[p*XL +: XL];
    ncnt[0] = 0;
    for (int r = 1; r < DP; r++) begin
      d = mcnt[r] - hits(r) + ((acc && int'(iss_rd) == r) ? 1 : 0);
      ncnt[r] = (d < 0) ? 0 : (d > PMAX ? PMAX : d);
    end
    @(posedge clk);
    mrf = nrf;
    mcnt = ncnt;
    #1;
  endtask

  task automatic idle();
    we = '0;
    wr_addr = '0;
    wr_data = '0;
    iss_valid = 1'b0;
    iss_rd = '0;
  endtask

  task automatic check_all(input string tag);
    int a;
    for (int i = 0; i < NR; i++) begin
      a = int'(rs_addr[i*AW +: AW]);
      check($sformatf("%s_d%0d", tag, i),
            64'(rs_data[i*XL +: XL]), 64'(exp_data(a)));
      check($sformatf("%s_b%0d", tag, i),
            64'(rs_busy[i]), 64'(exp_busy(a)));
    end
    check({tag, "_stall"}, 64'(iss_stall), 64'(exp_stall()));
  endtask

  initial begin
    model_clear();
    idle();
    rst = 1'b1;
    rs_addr = {5'd31, 5'd5};
    #3;
    check("rst_d0", 64'(rs_data[0 +: XL]), 64'h0);
    check("rst_d1", 64'(rs_data[XL +: XL]), 64'h0);
    check("rst_busy", 64'(rs_busy), 64'h0);
    check("rst_stall", 64'(iss_stall), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    we = 2'b01;
    wr_addr[0 +: AW] = 5'd5;
    wr_data[0 +: XL] = 32'hDEADBEEF;
    rs_addr = {5'd0, 5'd5};
    #1;
    check("x5_same", 64'(rs_data[0 +: XL]),
          BYP ? 64'hDEADBEEF : 64'h0);
    tick();
    idle();
    #1;
    check("x5_next", 64'(rs_data[0 +: XL]), 64'hDEADBEEF);

    we = 2'b11;
    wr_addr = '0;
    wr_data = {32'hFFFFFFFF, 32'hFFFFFFFF};
    iss_valid = 1'b1;
    iss_rd = 5'd0;
    rs_addr = {5'd0, 5'd0};
    #1;
    check("x0_d", 64'(rs_data[0 +: XL]), 64'h0);
    check("x0_busy", 64'(rs_busy), 64'h0);
    check("x0_stall", 64'(iss_stall), 64'h0);
    tick();
    idle();
    #1;
    check("x0_after", 64'(rs_data[XL +: XL]), 64'h0);

    we = 2'b11;
    wr_addr = {5'd7, 5'd7};
    wr_data = {32'h2, 32'h1};
    tick();
    idle();
    rs_addr = {5'd7, 5'd7};
    #1;
    check("coll_x7", 64'(rs_data[0 +: XL]), 64'h2);

    rs_addr = {5'd0, 5'd3};
    for (int n = 0; n < 3; n++) begin
      iss_valid = 1'b1;
      iss_rd = 5'd3;
      #1;
      check($sformatf("iss_x3_%0d", n), 64'(iss_stall), 64'h0);
      tick();
    end
    check("x3_busy3", 64'(rs_busy[0]), 64'h1);
    #1;
    check("x3_full", 64'(iss_stall), 64'h1);
    tick();
    we = 2'b01;
    wr_addr[0 +: AW] = 5'd3;
    #1;
    check("x3_wr_iss", 64'(iss_stall), 64'h0);
    tick();
    idle();
    iss_valid = 1'b1;
    iss_rd = 5'd3;
    #1;
    check("x3_still3", 64'(iss_stall), 64'h1);
    iss_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      we = 2'b10;
      wr_addr[AW +: AW] = 5'd3;
      tick();
      idle();
      #1;
      check($sformatf("x3_drain%0d", n), 64'(rs_busy[0]),
            (n < 2) ? 64'h1 : 64'h0);
    end

    we = 2'b01;
    wr_addr[0 +: AW] = 5'd9;
    wr_data[0 +: XL] = 32'h55;
    tick();
    idle();
    iss_valid = 1'b1;
    iss_rd = 5'd9;
    tick();
    tick();
    idle();
    rs_addr = {5'd9, 5'd9};
    #1;
    check("x9_busy", 64'(rs_busy[0]), 64'h1);
    check("x9_data", 64'(rs_data[0 +: XL]), 64'h55);
    rst = 1'b1;
    #1;
    check("x9_rst_busy", 64'(rs_busy[0]), 64'h0);
    check("x9_rst_data", 64'(rs_data[0 +: XL]), 64'h0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NW; p++) begin
        we[p] = ($urandom_range(0, 3) == 0);
        wr_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
        wr_data[p*XL +: XL] = $urandom;
      end
      iss_valid = ($urandom_range(0, 9) < 7);
      iss_rd = AW'($urandom_range(0, 7));
      for (int i = 0; i < NR; i++)
        rs_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
      #1;
      check_all("rnd");
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
